// File: rtl/eq_gen_pkg.sv
// Shared types and LFSR helpers for the equality-vector generator.
package eq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Right-shifting Galois tap masks giving a maximal-length sequence,
    // indexed by operand width (4..8).
    localparam logic [8:4][7:0] TAPS = {8'hB8, 8'h60, 8'h30, 8'h14, 8'h0C};

    // One Galois step on a state held in the low w bits of s.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s, input int w);
        return (s >> 1) ^ (s[0] ? TAPS[4'(w)] : 8'h00);
    endfunction

endpackage

// File: rtl/eq_lfsr.sv
// Combinational one- and two-step lookahead of the Galois LFSR.
module eq_lfsr
    import eq_gen_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] s,
    output logic [W-1:0] step1,
    output logic [W-1:0] step2
);

    assign step1 = W'(lfsr_step(8'(s), W));
    assign step2 = W'(lfsr_step(8'(step1), W));

endmodule

// File: rtl/eq_vec_gen.sv
// Operand-pair generator for the equality comparator.
// Optional macro EQ_GEN_XZ_EN adds exp_case_eq and drives X into b[0]
// on selected vectors (simulation only).
module eq_vec_gen
    import eq_gen_pkg::*;
#(
    parameter int W        = 5,
    parameter int NUM_VEC  = 16,
    parameter int EQ_EVERY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] seed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         exp_eq,
    output logic         exp_ne,
`ifdef EQ_GEN_XZ_EN
    output logic         exp_case_eq,
`endif
    output logic [7:0]   vec_idx,
    output logic         busy,
    output logic         done
);

    state_t       state, nxt;
    logic [W-1:0] lfsr;
    logic [W-1:0] src;
    logic [W-1:0] st1, st2;
    logic [W-1:0] b_nxt;
    logic [7:0]   ld_idx;
    logic         load;
    logic         forced;

    // A new run seeds from the input (zero would lock the LFSR); otherwise
    // continue from the saved state.
    assign src    = (state == IDLE) ? ((seed == '0) ? '1 : seed) : lfsr;
    assign ld_idx = (state == IDLE) ? 8'd0 : vec_idx + 8'd1;
    assign forced = (int'(ld_idx) % EQ_EVERY) == (EQ_EVERY - 1);
    assign b_nxt  = forced ? src : st1;

    eq_lfsr #(.W(W)) u_lfsr (
        .s     (src),
        .step1 (st1),
        .step2 (st2)
    );

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign done      = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state and vector-load decision.
    always_comb begin
        nxt  = state;
        load = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    nxt  = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (vec_idx == 8'(NUM_VEC - 1)) nxt  = DONE;
                    else                            load = 1'b1;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

`ifdef EQ_GEN_XZ_EN
    logic xz_sel;
    assign xz_sel = (int'(ld_idx) % EQ_EVERY) == 1;
`endif

    // Vector registers: load a pair and its golden flags; the LFSR always
    // advances two steps per vector so forced pairs do not shift the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr    <= '1;
            a       <= '0;
            b       <= '0;
            exp_eq  <= 1'b0;
            exp_ne  <= 1'b0;
            vec_idx <= 8'd0;
`ifdef EQ_GEN_XZ_EN
            exp_case_eq <= 1'b0;
`endif
        end else if (load) begin
            lfsr    <= st2;
            a       <= src;
            b       <= b_nxt;
            exp_eq  <= (src == b_nxt);
            exp_ne  <= (src != b_nxt);
            vec_idx <= ld_idx;
`ifdef EQ_GEN_XZ_EN
            if (xz_sel) begin
                b[0]        <= 1'bx;
                exp_eq      <= 1'bx;
                exp_ne      <= 1'bx;
                exp_case_eq <= 1'b0;
            end else begin
                exp_case_eq <= (src == b_nxt);
            end
`endif
        end
    end

endmodule

// File: tb/tb_eq_vec_gen.sv
// Self-checking bench for eq_vec_gen (W=5, NUM_VEC=16, EQ_EVERY=4).
module tb_eq_vec_gen;

    localparam int W  = 5;
    localparam int NV = 16;
    localparam int EE = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] seed = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] a, b;
    logic         exp_eq, exp_ne;
    logic [7:0]   vec_idx;
    logic         busy, done;
`ifdef EQ_GEN_XZ_EN
    logic         exp_case_eq;
`endif

    int checks = 0;
    int failures = 0;

    eq_vec_gen #(.W(W), .NUM_VEC(NV), .EQ_EVERY(EE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .exp_eq    (exp_eq),
        .exp_ne    (exp_ne),
`ifdef EQ_GEN_XZ_EN
        .exp_case_eq (exp_case_eq),
`endif
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: W=5 Galois step with tap mask 0x14.
    function automatic logic [4:0] ref_step(input logic [4:0] s);
        return (s >> 1) ^ ((s & 5'd1) != 0 ? 5'h14 : 5'h00);
    endfunction

    // Reference vector k of a run: {valid, idx, a, b, eq, ne}.
    function automatic logic [20:0] ref_vec(input logic [4:0] sd, input int k);
        logic [4:0] s, ea, eb;
        logic       eq, ne;
        s = (sd == 0) ? 5'h1F : sd;
        for (int i = 0; i < k; i++) s = ref_step(ref_step(s));
        ea = s;
        eb = (k % EE == EE - 1) ? s : ref_step(s);
        eq = (ea == eb);
        ne = !eq;
`ifdef EQ_GEN_XZ_EN
        if (k % EE == 1) begin
            eb[0] = 1'bx;
            eq = 1'bx;
            ne = 1'bx;
        end
`endif
        return {1'b1, 8'(k), ea, eb, eq, ne};
    endfunction

    task automatic do_start(input logic [4:0] sd);
        seed = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        if ({out_valid, a, b, exp_eq, exp_ne, vec_idx, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h want=0",
                     {out_valid, a, b, exp_eq, exp_ne, vec_idx, busy, done});
        end
        checks++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_known_vectors();
        logic [20:0] want [4];
        want[0] = {1'b1, 8'd0, 5'h01, 5'h14, 1'b0, 1'b1};
        want[1] = {1'b1, 8'd1, 5'h0A, 5'h05, 1'b0, 1'b1};
        want[2] = {1'b1, 8'd2, 5'h16, 5'h0B, 1'b0, 1'b1};
        want[3] = {1'b1, 8'd3, 5'h11, 5'h11, 1'b1, 1'b0};
`ifdef EQ_GEN_XZ_EN
        want[1] = {1'b1, 8'd1, 5'h0A, 4'h2, 1'bx, 1'bx, 1'bx};
`endif
        out_ready = 1'b1;
        do_start(5'h01);
        for (int k = 0; k < 4; k++) begin
            if ({out_valid, vec_idx, a, b, exp_eq, exp_ne} !== want[k]) begin
                failures++;
                $display("FAIL known_vec%0d got=%h want=%h", k,
                         {out_valid, vec_idx, a, b, exp_eq, exp_ne}, want[k]);
            end
            checks++;
            tick();
        end
        for (int i = 0; i < 40 && !done; i++) tick();
        tick();
    endtask

    task automatic test_full_run();
        logic [4:0] sd;
        sd = 5'($urandom_range(1, 31));
        out_ready = 1'b1;
        do_start(sd);
        for (int k = 0; k < NV; k++) begin
            if ({out_valid, vec_idx, a, b, exp_eq, exp_ne} !== ref_vec(sd, k)) begin
                failures++;
                $display("FAIL full_run_vec%0d got=%h want=%h", k,
                         {out_valid, vec_idx, a, b, exp_eq, exp_ne}, ref_vec(sd, k));
            end
            checks++;
            tick();
        end
        if ({done, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL full_run_done got=%b want=100", {done, out_valid, busy});
        end
        checks++;
        tick();
        if ({done, out_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL full_run_after got=%b want=000", {done, out_valid, busy});
        end
        checks++;
    endtask

    task automatic test_stall();
        logic [4:0] sd;
        sd = 5'($urandom_range(1, 31));
        out_ready = 1'b1;
        do_start(sd);
        for (int k = 0; k < 5; k++) tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if ({out_valid, vec_idx, a, b, exp_eq, exp_ne} !== ref_vec(sd, 5)) begin
                failures++;
                $display("FAIL stall_hold_c%0d got=%h want=%h", c,
                         {out_valid, vec_idx, a, b, exp_eq, exp_ne}, ref_vec(sd, 5));
            end
            checks++;
            tick();
        end
        out_ready = 1'b1;
        for (int k = 5; k < NV; k++) begin
            if ({out_valid, vec_idx, a, b, exp_eq, exp_ne} !== ref_vec(sd, k)) begin
                failures++;
                $display("FAIL stall_resume_vec%0d got=%h want=%h", k,
                         {out_valid, vec_idx, a, b, exp_eq, exp_ne}, ref_vec(sd, k));
            end
            checks++;
            tick();
        end
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL stall_done got=%b want=1", done);
        end
        checks++;
        tick();
    endtask

    task automatic test_seed_zero();
        out_ready = 1'b1;
        do_start(5'h00);
        if ({vec_idx, a, b} !== {8'd0, 5'h1F, 5'h1B}) begin
            failures++;
            $display("FAIL seed_zero got=%h want=%h", {vec_idx, a, b}, {8'd0, 5'h1F, 5'h1B});
        end
        checks++;
        for (int i = 0; i < 40 && !done; i++) tick();
        tick();
    endtask

    task automatic test_random_ready();
        logic [4:0] sd;
        int         k;
        bit         fin;
        sd = 5'($urandom);
        k = 0;
        fin = 0;
        out_ready = 1'b0;
        do_start(sd);
        for (int c = 0; c < 200 && !fin; c++) begin
            out_ready = 1'($urandom);
            if (done) begin
                fin = 1;
            end else begin
                if ({out_valid, vec_idx, a, b, exp_eq, exp_ne} !== ref_vec(sd, k)) begin
                    failures++;
                    $display("FAIL rand_ready_vec%0d got=%h want=%h", k,
                             {out_valid, vec_idx, a, b, exp_eq, exp_ne}, ref_vec(sd, k));
                end
                checks++;
                if (out_ready) k++;
                tick();
            end
        end
        if (!fin || k != NV) begin
            failures++;
            $display("FAIL rand_ready_count got=%0d done=%0d want=%0d done=1", k, fin, NV);
        end
        checks++;
        tick();
    endtask

    task automatic test_start_in_done();
        logic [4:0] sd;
        out_ready = 1'b1;
        do_start(5'h07);
        for (int i = 0; i < 40 && !done; i++) tick();
        sd = 5'($urandom_range(1, 31));
        seed = sd;
        start = 1'b1;
        tick();
        if ({out_valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL start_in_done_ignored got=%b want=000", {out_valid, busy, done});
        end
        checks++;
        tick();
        start = 1'b0;
        if ({out_valid, vec_idx, a, b, exp_eq, exp_ne} !== ref_vec(sd, 0)) begin
            failures++;
            $display("FAIL start_after_done got=%h want=%h",
                     {out_valid, vec_idx, a, b, exp_eq, exp_ne}, ref_vec(sd, 0));
        end
        checks++;
        for (int i = 0; i < 40 && !done; i++) tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [4:0] sd;
        bit         seen;
        sd = 5'($urandom_range(1, 31));
        out_ready = 1'b1;
        do_start(sd);
        for (int k = 0; k < 7; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        if ({out_valid, a, b, exp_eq, exp_ne, vec_idx, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear got=%h want=0",
                     {out_valid, a, b, exp_eq, exp_ne, vec_idx, busy, done});
        end
        checks++;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 1) rst_n = 1'b1;
            if (done) seen = 1;
        end
        if (seen) begin
            failures++;
            $display("FAIL reset_mid_no_done got=1 want=0");
        end
        checks++;
        do_start(sd);
        if ({out_valid, vec_idx, a, b, exp_eq, exp_ne} !== ref_vec(sd, 0)) begin
            failures++;
            $display("FAIL reset_mid_restart got=%h want=%h",
                     {out_valid, vec_idx, a, b, exp_eq, exp_ne}, ref_vec(sd, 0));
        end
        checks++;
        for (int i = 0; i < 40 && !done; i++) tick();
        tick();
    endtask

`ifdef EQ_GEN_XZ_EN
    task automatic test_xz();
        out_ready = 1'b1;
        do_start(5'h01);
        tick();
        if ({b[0], exp_eq, exp_case_eq} !== {1'bx, 1'bx, 1'b0}) begin
            failures++;
            $display("FAIL xz_vec1 got=%b want=xx0", {b[0], exp_eq, exp_case_eq});
        end
        checks++;
        tick();
        tick();
        if (exp_case_eq !== 1'b1) begin
            failures++;
            $display("FAIL xz_vec3 got=%b want=1", exp_case_eq);
        end
        checks++;
        for (int i = 0; i < 40 && !done; i++) tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_known_vectors();
        test_full_run();
        test_stall();
        test_seed_zero();
        test_random_ready();
        test_random_ready();
        test_start_in_done();
        test_reset_mid();
`ifdef EQ_GEN_XZ_EN
        test_xz();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
